// File: rtl/video_raster_gen.sv
// video_raster_gen
//   Raster video generator with configurable timing. Produces hsync/vsync,
//   active-low blanking and a pixel stream at 1, 2 or 4 bits per pixel. Pixel
//   data is read from an external framebuffer one 16-bit word at a time
//   through a fixed-latency read port (data valid the clk after rd_en). Two
//   screen pages are selectable.
//
// Ports
//   clk       system clock
//   rst_n     synchronous reset, active low (has priority over ce)
//   ce        pixel clock enable, never high on two consecutive clks
//   bpp_mode  0 = 1bpp, 1 = 2bpp, 2 = 4bpp, 3 = 1bpp
//   page_sel  screen page select (latched once per frame)
//   rd_en     one-clk read strobe to the framebuffer
//   rd_addr   word address of the read
//   rd_data   read data, valid in the clk after rd_en
//   hsync     horizontal sync, active high
//   vsync     vertical sync, active high
//   _hblank   low during horizontal blanking
//   _vblank   low during vertical blanking
//   video_en  high while pix carries a visible pixel
//   pix       pixel index, zero-extended to 4 bits
module video_raster_gen #(
  parameter int H_VISIBLE   = 512,
  parameter int H_TOTAL     = 704,
  parameter int HSYNC_START = 540,
  parameter int HSYNC_END   = 608,
  parameter int V_START     = 21,
  parameter int V_END       = 362,
  parameter int V_TOTAL     = 370,
  parameter int VSYNC_START = 365,
  parameter int VSYNC_END   = 369,
  parameter int ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] PAGE0_BASE = '0,
  parameter logic [ADDR_W-1:0] PAGE1_BASE = ADDR_W'(16'h4000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic [1:0]        bpp_mode,
  input  logic              page_sel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              hsync,
  output logic              vsync,
  output logic              _hblank,
  output logic              _vblank,
  output logic              video_en,
  output logic [3:0]        pix
);

  localparam int XW = $clog2(H_TOTAL + 1);
  localparam int YW = $clog2(V_TOTAL + 1);

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_VIS  = XW'(H_VISIBLE);
  localparam logic [XW-1:0] X_HS0  = XW'(HSYNC_START);
  localparam logic [XW-1:0] X_HS1  = XW'(HSYNC_END);

  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_PRE  = YW'(V_START - 1);
  localparam logic [YW-1:0] Y_VIS0 = YW'(V_START);
  localparam logic [YW-1:0] Y_VIS1 = YW'(V_END);
  localparam logic [YW-1:0] Y_VS0  = YW'(VSYNC_START);
  localparam logic [YW-1:0] Y_VS1  = YW'(VSYNC_END);

  // Words per line at 1bpp; higher depths scale this by a left shift.
  localparam logic signed [31:0] WPL_1BPP  = 32'(H_VISIBLE / 16);
  localparam logic signed [31:0] V_START_S = 32'(V_START);

  // Depth is carried as log2(bpp): 0 = 1bpp, 1 = 2bpp, 2 = 4bpp.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? 2'd0 : m;
  endfunction

  function automatic logic line_visible(input logic [YW-1:0] y);
    return (y >= Y_VIS0) && (y <= Y_VIS1);
  endfunction

  function automatic logic [3:0] msb_bits(input logic [15:0] w, input logic [1:0] sh);
    case (sh)
      2'd1:    return {2'b00, w[15:14]};
      2'd2:    return w[15:12];
      default: return {3'b000, w[15]};
    endcase
  endfunction

  function automatic logic [15:0] shift_out(input logic [15:0] w, input logic [1:0] sh);
    case (sh)
      2'd1:    return {w[13:0], 2'b00};
      2'd2:    return {w[11:0], 4'b0000};
      default: return {w[14:0], 1'b0};
    endcase
  endfunction

  logic [XW-1:0] xpos;
  logic [YW-1:0] ypos;
  logic [1:0]    sh_q;
  logic          page_q;
  logic          rd_vld_p1;
  logic [15:0]   fetch_buf_p2;
  logic [15:0]   shift_reg_p2;

  logic              x_last, y_last, latch_now;
  logic              line_vis_cur, line_vis_nxt, h_vis, pix_vis;
  logic              req, load;
  logic [XW-1:0]     x_inc, x_nxt, ppw_mask, k_idx;
  logic [YW-1:0]     y_inc, y_nxt, req_line;
  logic [1:0]        eff_sh;
  logic              eff_page;
  logic [ADDR_W-1:0] eff_base, req_addr;
  logic signed [31:0] line_off;
  logic [15:0]       load_word, cur_word, shifted;
  logic [3:0]        top_bits;

  always_comb begin
    x_last       = (xpos == X_LAST);
    y_last       = (ypos == Y_LAST);
    x_inc        = xpos + XW'(1);
    y_inc        = ypos + YW'(1);
    x_nxt        = x_last ? '0 : x_inc;
    y_nxt        = x_last ? (y_last ? '0 : y_inc) : ypos;
    line_vis_cur = line_visible(ypos);
    line_vis_nxt = line_visible(y_nxt);
    h_vis        = (xpos < X_VIS);
    pix_vis      = h_vis && line_vis_cur;

    // The mode/page latch ce also issues word 0 of the first visible line,
    // so that request must already see the newly sampled mode and page.
    latch_now = x_last && (ypos == Y_PRE);
    eff_sh    = latch_now ? norm_mode(bpp_mode) : sh_q;
    eff_page  = latch_now ? page_sel : page_q;
    eff_base  = eff_page ? PAGE1_BASE : PAGE0_BASE;
    ppw_mask  = XW'(4'hF >> eff_sh);

    // Word k is requested one pixel before it is needed; word 0 of a line is
    // requested from the last column of the line before.
    req      = 1'b0;
    k_idx    = '0;
    req_line = ypos;
    if (x_last) begin
      req      = line_vis_nxt;
      req_line = y_nxt;
    end else if (line_vis_cur && (x_inc < X_VIS) && ((x_inc & ppw_mask) == '0)) begin
      req   = 1'b1;
      k_idx = x_inc >> (3'd4 - {1'b0, eff_sh});
    end
    line_off = $signed(32'(req_line)) - V_START_S;
    req_addr = eff_base + ADDR_W'((line_off * WPL_1BPP) <<< eff_sh) + ADDR_W'(k_idx);

    // At the fastest ce rate the word lands in the same clk it is loaded,
    // so the load bypasses the fetch buffer in that case.
    load      = pix_vis && ((xpos & ppw_mask) == '0);
    load_word = rd_vld_p1 ? rd_data : fetch_buf_p2;
    cur_word  = load ? load_word : shift_reg_p2;
    top_bits  = msb_bits(cur_word, eff_sh);
    shifted   = shift_out(cur_word, eff_sh);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xpos         <= '0;
      ypos         <= '0;
      sh_q         <= 2'd0;
      page_q       <= 1'b0;
      hsync        <= 1'b0;
      vsync        <= 1'b0;
      _hblank      <= 1'b1;
      _vblank      <= 1'b0;
      video_en     <= 1'b0;
      pix          <= 4'h0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      rd_vld_p1    <= 1'b0;
      fetch_buf_p2 <= 16'h0000;
      shift_reg_p2 <= 16'h0000;
    end else begin
      // p0 -> p1: read strobe ages into the data-valid flag
      rd_en     <= 1'b0;
      rd_vld_p1 <= rd_en;
      // p1 -> p2: returned word lands in the fetch buffer
      if (rd_vld_p1) begin
        fetch_buf_p2 <= rd_data;
      end
      if (ce) begin
        xpos <= x_nxt;
        ypos <= y_nxt;
        if (latch_now) begin
          sh_q   <= norm_mode(bpp_mode);
          page_q <= page_sel;
        end
        hsync   <= (xpos >= X_HS0) && (xpos < X_HS1);
        vsync   <= (ypos >= Y_VS0) && (ypos <= Y_VS1);
        _hblank <= h_vis;
        _vblank <= line_vis_cur;
        if (req) begin
          rd_en   <= 1'b1;
          rd_addr <= req_addr;
        end
        if (pix_vis) begin
          pix          <= top_bits;
          video_en     <= 1'b1;
          shift_reg_p2 <= shifted;
        end else begin
          pix      <= 4'h0;
          video_en <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_raster_gen.sv
// Testbench for video_raster_gen on a shrunk timing set: 48x10 total,
// 32x4 visible (lines 3..6), hsync on columns 36..39, vsync on lines 8..9,
// 8-bit word addresses, page 1 near the top of the address space.
module tb_video_raster_gen;

  localparam int HV  = 32;
  localparam int HT  = 48;
  localparam int HSS = 36;
  localparam int HSE = 40;
  localparam int VST = 3;
  localparam int VEN = 6;
  localparam int VT  = 10;
  localparam int VSS = 8;
  localparam int VSE = 9;
  localparam int AW  = 8;
  localparam int P0  = 8'h00;
  localparam int P1  = 8'hFC;

  logic          clk;
  logic          rst_n;
  logic          ce;
  logic [1:0]    bpp_mode;
  logic          page_sel;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic          hsync, vsync, hblank_n, vblank_n, video_en;
  logic [3:0]    pix;

  video_raster_gen #(
    .H_VISIBLE(HV), .H_TOTAL(HT), .HSYNC_START(HSS), .HSYNC_END(HSE),
    .V_START(VST), .V_END(VEN), .V_TOTAL(VT),
    .VSYNC_START(VSS), .VSYNC_END(VSE), .ADDR_W(AW),
    .PAGE0_BASE(8'(P0)), .PAGE1_BASE(8'(P1))
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .bpp_mode(bpp_mode), .page_sel(page_sel),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .hsync(hsync), .vsync(vsync), ._hblank(hblank_n), ._vblank(vblank_n),
    .video_en(video_en), .pix(pix)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Framebuffer: answers one clk after rd_en, garbage otherwise.
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    else       rd_data <= 16'($urandom);
  end

  typedef struct packed {
    logic [8:0] out;   // {hsync, vsync, _hblank, _vblank, video_en, pix}
    logic       rd;
    logic [7:0] addr;
    logic       chk;   // compare rd_addr even without a read
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_on = 1'b0;

  // Reference model state
  int mx, my, msh, mpage;

  // Per-frame statistics gathered by the monitor
  int          rd_cnt, ven_cnt, hs_cnt, vs_cnt;
  logic [7:0]  first_addr, addr8, prev_addr;
  bit          wrapped;
  logic [3:0]  cap [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  function automatic int base_of(input int pg);
    return pg != 0 ? P1 : P0;
  endfunction

  function automatic logic [3:0] model_pix(input int x, input int y);
    int bpp, ppw, wpl, k, a, w, sh;
    bpp = 1 << msh;
    ppw = 16 / bpp;
    wpl = HV * bpp / 16;
    k   = x / ppw;
    a   = (base_of(mpage) + (y - VST) * wpl + k) & 255;
    w   = int'(mem[a]);
    sh  = 16 - ((x % ppw) + 1) * bpp;
    return 4'((w >> sh) & ((1 << bpp) - 1));
  endfunction

  task automatic model_ce();
    exp_t e;
    int   tl, k, ppw, nx, addr;
    bit   req, hs, vs, hb, vb, ven;
    hs  = (mx >= HSS) && (mx < HSE);
    vs  = (my >= VSS) && (my <= VSE);
    hb  = (mx < HV);
    vb  = (my >= VST) && (my <= VEN);
    ven = hb && vb;
    e.out = {hs, vs, hb, vb, ven, (ven ? model_pix(mx, my) : 4'h0)};
    if (mx == HT - 1 && my == VST - 1) begin
      msh   = (bpp_mode == 2'd3) ? 0 : int'(bpp_mode);
      mpage = int'(page_sel);
    end
    if (mx == HT - 1) begin
      tl  = (my == VT - 1) ? 0 : my + 1;
      k   = 0;
      req = (tl >= VST) && (tl <= VEN);
    end else begin
      ppw = 16 >> msh;
      nx  = mx + 1;
      tl  = my;
      k   = nx / ppw;
      req = (my >= VST) && (my <= VEN) && (nx < HV) && (nx % ppw == 0);
    end
    addr   = (base_of(mpage) + (tl - VST) * ((HV / 16) << msh) + k) & 255;
    e.rd   = req;
    e.addr = req ? 8'(addr) : 8'h00;
    e.chk  = 1'b0;
    exp_q.push_back(e);
    if (mx == HT - 1) begin
      mx = 0;
      my = (my == VT - 1) ? 0 : my + 1;
    end else begin
      mx++;
    end
  endtask

  task automatic step(input bit c);
    @(negedge clk);
    ce = c;
    if (c) model_ce();
  endtask

  task automatic pix_tick();
    step(1'b1);
    step(1'b0);
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    e.out  = 9'b0_0_1_0_0_0000;
    e.rd   = 1'b0;
    e.addr = 8'h00;
    e.chk  = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n  = 1'b0;
      ce     = 1'b0;
      mon_on = 1'b1;
      exp_q.push_back(e);
    end
    mx = 0; my = 0; msh = 0; mpage = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_stats();
    rd_cnt = 0; ven_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    first_addr = 8'h00; addr8 = 8'h00; prev_addr = 8'h00; wrapped = 1'b0;
    for (int i = 0; i < 16; i++) cap[i] = 4'h0;
  endtask

  task automatic run_frame(input logic [1:0] nb, input logic np, input int chg_line);
    clear_stats();
    for (int y = 0; y < VT; y++) begin
      if (y == chg_line) begin
        bpp_mode = nb;
        page_sel = np;
      end
      for (int x = 0; x < HT; x++) pix_tick();
    end
  endtask

  task automatic frame_checks(input int exp_rd, input logic [63:0] cap_exp, input logic [63:0] mask);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) p = {p[59:0], cap[i]};
    check("reads_per_frame", 64'(rd_cnt), 64'(exp_rd));
    check("video_en_per_frame", 64'(ven_cnt), 64'd128);
    check("hsync_per_frame", 64'(hs_cnt), 64'd40);
    check("vsync_per_frame", 64'(vs_cnt), 64'd96);
    check("first_pixels", p & mask, cap_exp & mask);
  endtask

  // Monitor: pops one expectation per ce or reset edge, otherwise checks
  // that the outputs hold and no read is strobed.
  exp_t mon_e, mon_last;
  bit   mon_c, mon_r;
  always @(posedge clk) begin
    mon_c = ce;
    mon_r = !rst_n;
    #1;
    if (mon_on) begin
      if (mon_c || mon_r) begin
        check("sb_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("outputs", 64'({hsync, vsync, hblank_n, vblank_n, video_en, pix}), 64'(mon_e.out));
          check("rd_en", 64'(rd_en), 64'(mon_e.rd));
          if (mon_e.rd || mon_e.chk) check("rd_addr", 64'(rd_addr), 64'(mon_e.addr));
          mon_last = mon_e;
        end
        if (mon_c && !mon_r) begin
          if (video_en) begin
            if (ven_cnt < 16) cap[ven_cnt] = pix;
            ven_cnt++;
          end
          if (hsync) hs_cnt++;
          if (vsync) vs_cnt++;
          if (rd_en) begin
            if (rd_cnt == 0) first_addr = rd_addr;
            if (rd_cnt == 8) addr8 = rd_addr;
            if (prev_addr == 8'hFF && rd_addr == 8'h00) wrapped = 1'b1;
            prev_addr = rd_addr;
            rd_cnt++;
          end
        end
      end else begin
        check("hold_outputs", 64'({hsync, vsync, hblank_n, vblank_n, video_en, pix}), 64'(mon_last.out));
        check("rd_en_idle", 64'(rd_en), 64'd0);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    ce       = 1'b0;
    bpp_mode = 2'd0;
    page_sel = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 40503 + 12345);
    mem[8'h00] = 16'h8001;
    mem[8'hFC] = 16'h1234;
    clear_stats();

    do_reset(2);

    // 1bpp page 0; switch inputs mid-frame to 4bpp page 1 for the next frame
    run_frame(2'd2, 1'b1, 4);
    frame_checks(8, 64'h1000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
    check("first_rd_addr", 64'(first_addr), 64'h00);

    // 4bpp page 1
    run_frame(2'd1, 1'b0, 5);
    frame_checks(32, 64'h1234_0000_0000_0000, 64'hFFFF_0000_0000_0000);
    check("line1_word0_addr", 64'(addr8), 64'h04);

    // 2bpp page 0
    run_frame(2'd3, 1'b1, 5);
    frame_checks(16, 64'h2000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000);

    // reserved mode -> 1bpp, page 1, address wraps past 0xFF
    run_frame(2'd0, 1'b0, 5);
    frame_checks(8, 64'h0001_0010_0011_0100, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addr_wrap", 64'(wrapped), 64'd1);

    // Reset right after the word-1 request of line 5 (read outstanding)
    for (int i = 0; i < 5 * HT + 15; i++) pix_tick();
    step(1'b1);
    do_reset(2);

    run_frame(2'd0, 1'b0, 5);
    frame_checks(8, 64'h1000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
    check("first_rd_addr_after_reset", 64'(first_addr), 64'h00);

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
